// File: rtl/parity_stream_unit_pkg.sv
// Shared types and helpers for the parity stream unit and its word generator.
package parity_pkg;

  // Frame tracking states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Widest data word the parity helper accepts; narrower words are zero-extended.
  localparam int PAR_MAX_W = 64;

  // Reduction XOR of a zero-extended word, inverted for odd parity.
  function automatic logic parity_of(input logic [PAR_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_stream_unit_if.sv
// Word stream bus: input handshake plus registered output stage.
interface parity_stream_unit_if #(
  parameter int DATA_W = 7
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_par;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W:0]   out_data;
  logic              word_err;

  modport master (
    output in_valid, in_data, in_par, out_ready,
    input  in_ready, out_valid, out_data, word_err
  );

  modport slave (
    input  in_valid, in_data, in_par, out_ready,
    output in_ready, out_valid, out_data, word_err
  );
endinterface

// File: rtl/parity_stream_unit_word_gen.sv
// Combinational per-word parity generator and received-parity checker.
module parity_word_gen
  import parity_pkg::*;
#(
  parameter int DATA_W = 7
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_odd,
  input  logic              i_par,
  output logic              o_gen_par,
  output logic              o_mismatch
);

  logic [PAR_MAX_W-1:0] w_data_ext;

  // Zero-extend the word, generate parity and compare with the received bit.
  always_comb begin
    w_data_ext               = '0;
    w_data_ext[DATA_W-1:0]   = i_data;
    o_gen_par                = parity_of(w_data_ext, i_odd);
    o_mismatch               = (i_par != o_gen_par);
  end

endmodule

// File: rtl/parity_stream_unit.sv
// Streaming parity unit: per-word parity append/check through a one-entry
// output register, plus frame-level parity/error reporting and an error count.
module parity_stream_unit
  import parity_pkg::*;
#(
  parameter int DATA_W    = 7,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 mode_odd,
  parity_stream_unit_if.slave  bus,
  output logic                 frame_done,
  output logic                 frame_par,
  output logic                 frame_err,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int               IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [1:0]       S_IDLE   = IDLE;
  localparam logic [1:0]       S_ACCUM  = ACCUM;
  localparam logic [1:0]       S_REPORT = REPORT;

  logic              w_gen_par;
  logic              w_mismatch;
  logic              w_data_par;
  logic              w_in_ready;
  logic              w_accept;

  logic              r_out_valid;
  logic [DATA_W:0]   r_out_data;
  logic              r_word_err;

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic              r_par_acc;
  logic              r_err_acc;
  logic              r_frame_done;
  logic              r_frame_par;
  logic              r_frame_err;
  logic [CNT_W-1:0]  r_err_cnt;

  logic [1:0]        w_state_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic              w_par_acc_nxt;
  logic              w_err_acc_nxt;
  logic              w_report_load;
  logic              w_final_par;
  logic              w_final_err;

  parity_word_gen #(.DATA_W(DATA_W)) u_word_gen (
    .i_data     (bus.in_data),
    .i_odd      (mode_odd),
    .i_par      (bus.in_par),
    .o_gen_par  (w_gen_par),
    .o_mismatch (w_mismatch)
  );

  // Mode-independent data parity feeds the frame accumulator.
  assign w_data_par = w_gen_par ^ mode_odd;

  // Ready depends only on state and the output register, never on in_valid.
  assign w_in_ready = rst_n && (r_state != S_REPORT) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.word_err  = r_word_err;
  assign frame_done    = r_frame_done;
  assign frame_par     = r_frame_par;
  assign frame_err     = r_frame_err;
  assign err_cnt       = r_err_cnt;

  // One-entry output register: load on accept, drain on handshake, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_word_err  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= {w_gen_par, bus.in_data};
      r_word_err  <= w_mismatch;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Frame next-state: clr discards the frame; the last accept moves to REPORT.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_par_acc_nxt = r_par_acc;
    w_err_acc_nxt = r_err_acc;
    w_report_load = 1'b0;
    w_final_par   = r_par_acc ^ w_data_par;
    w_final_err   = r_err_acc | w_mismatch;
    if (clr) begin
      w_state_nxt   = S_IDLE;
      w_idx_nxt     = '0;
      w_par_acc_nxt = 1'b0;
      w_err_acc_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_state_nxt   = S_ACCUM;
            w_idx_nxt     = IDX_W'(1);
            w_par_acc_nxt = w_data_par;
            w_err_acc_nxt = w_mismatch;
          end else begin
            w_state_nxt   = S_IDLE;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            if (r_idx == LAST_IDX) begin
              w_state_nxt   = S_REPORT;
              w_report_load = 1'b1;
            end else begin
              w_idx_nxt     = r_idx + IDX_W'(1);
            end
            w_par_acc_nxt = w_final_par;
            w_err_acc_nxt = w_final_err;
          end else begin
            w_state_nxt   = S_ACCUM;
          end
        end
        S_REPORT: begin
          w_state_nxt   = S_IDLE;
          w_idx_nxt     = '0;
          w_par_acc_nxt = 1'b0;
          w_err_acc_nxt = 1'b0;
        end
        default: begin
          w_state_nxt   = S_IDLE;
          w_idx_nxt     = '0;
          w_par_acc_nxt = 1'b0;
          w_err_acc_nxt = 1'b0;
        end
      endcase
    end
  end

  // Frame registers; the report outputs hold until the next completed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_par_acc    <= 1'b0;
      r_err_acc    <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_par  <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_par_acc    <= w_par_acc_nxt;
      r_err_acc    <= w_err_acc_nxt;
      r_frame_done <= w_report_load;
      if (w_report_load) begin
        r_frame_par <= w_final_par;
        r_frame_err <= w_final_err;
      end
    end
  end

  // Saturating count of accepted mismatching words; clr takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (clr) begin
      r_err_cnt <= '0;
    end else if (w_accept && w_mismatch && (r_err_cnt != CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_parity_stream_unit.sv
// Self-checking bench: two units (CNT_W=8 and CNT_W=2) share one stimulus
// stream and are compared every cycle against a transaction-level model.
module tb_parity_stream_unit;

  localparam int DATA_W    = 7;
  localparam int FRAME_LEN = 8;

  logic clk;
  logic rst_n;
  logic clr;
  logic mode_odd;
  logic frame_done_a, frame_par_a, frame_err_a;
  logic frame_done_b, frame_par_b, frame_err_b;
  logic [7:0] err_cnt_a;
  logic [1:0] err_cnt_b;

  parity_stream_unit_if #(.DATA_W(DATA_W)) bus_a ();
  parity_stream_unit_if #(.DATA_W(DATA_W)) bus_b ();

  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.in_data   = bus_a.in_data;
  assign bus_b.in_par    = bus_a.in_par;
  assign bus_b.out_ready = bus_a.out_ready;

  parity_stream_unit #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode_odd(mode_odd), .bus(bus_a),
    .frame_done(frame_done_a), .frame_par(frame_par_a), .frame_err(frame_err_a),
    .err_cnt(err_cnt_a)
  );

  parity_stream_unit #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode_odd(mode_odd), .bus(bus_b),
    .frame_done(frame_done_b), .frame_par(frame_par_b), .frame_err(frame_err_b),
    .err_cnt(err_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  bit       m_ov, m_we, m_fd, m_fp, m_fe;
  bit [7:0] m_od;
  int       m_cnt_a, m_cnt_b;
  int       m_fwords[$];
  bit       m_fmis[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ov = 0; m_we = 0; m_fd = 0; m_fp = 0; m_fe = 0; m_od = 8'h00;
    m_cnt_a = 0; m_cnt_b = 0;
    m_fwords.delete(); m_fmis.delete();
  endfunction

  function automatic void model_update(input bit acc, input bit [6:0] d, input bit p,
                                       input bit m, input bit ordy, input bit c);
    bit gp, mis, new_fd;
    int ones;
    gp  = bit'($countones(d) % 2) ^ m;
    mis = (p != gp);
    new_fd = 0;
    if (c) begin
      m_fwords.delete(); m_fmis.delete();
      m_cnt_a = 0; m_cnt_b = 0;
    end else if (acc) begin
      m_fwords.push_back(int'(d));
      m_fmis.push_back(mis);
      if (mis) begin
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_b < 3) m_cnt_b++;
      end
      if (m_fwords.size() == FRAME_LEN) begin
        ones = 0;
        m_fe = 0;
        foreach (m_fwords[i]) ones += $countones(m_fwords[i]);
        foreach (m_fmis[i]) m_fe |= m_fmis[i];
        m_fp = bit'(ones % 2);
        new_fd = 1;
        m_fwords.delete(); m_fmis.delete();
      end
    end
    m_fd = new_fd;
    if (acc) begin
      m_ov = 1; m_od = {gp, d}; m_we = mis;
    end else if (ordy) begin
      m_ov = 0;
    end
  endfunction

  // One clock: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic step(input bit v, input bit [6:0] d, input bit p, input bit m,
                      input bit ordy, input bit c, output bit acc);
    bit exp_rdy;
    bus_a.in_valid = v; bus_a.in_data = d; bus_a.in_par = p;
    bus_a.out_ready = ordy; mode_odd = m; clr = c;
    @(negedge clk);
    exp_rdy = rst_n && !m_fd && (!m_ov || ordy);
    check_eq("in_ready",   32'(bus_a.in_ready),  32'(exp_rdy));
    check_eq("out_valid",  32'(bus_a.out_valid), 32'(m_ov));
    check_eq("out_data",   32'(bus_a.out_data),  32'(m_od));
    check_eq("word_err",   32'(bus_a.word_err),  32'(m_we));
    check_eq("frame_done", 32'(frame_done_a),    32'(m_fd));
    check_eq("frame_par",  32'(frame_par_a),     32'(m_fp));
    check_eq("frame_err",  32'(frame_err_a),     32'(m_fe));
    check_eq("err_cnt_a",  32'(err_cnt_a),       32'(m_cnt_a));
    check_eq("err_cnt_b",  32'(err_cnt_b),       32'(m_cnt_b));
    check_eq("frame_done_b", 32'(frame_done_b),  32'(m_fd));
    acc = v && exp_rdy;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_update(acc, d, p, m, ordy, c);
    #1;
  endtask

  // Present a word until it is accepted, with a bounded number of tries.
  task automatic send_word(input bit [6:0] d, input bit p, input bit m);
    bit acc;
    acc = 0;
    for (int t = 0; t < 6 && !acc; t++) step(1, d, p, m, 1, 0, acc);
    check_eq("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle_cycle(input bit c);
    bit acc;
    step(0, 7'h00, 0, 0, 1, c, acc);
  endtask

  initial begin
    bit acc;
    bit [6:0] d;
    bit [1:0] exp_sat [5];
    rst_n = 0; clr = 0; mode_odd = 0;
    bus_a.in_valid = 0; bus_a.in_data = '0; bus_a.in_par = 0; bus_a.out_ready = 0;
    model_reset();
    exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3; exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;

    // Reset state, including in_ready low while in reset.
    step(1, 7'h11, 0, 0, 1, 0, acc);
    step(1, 7'h11, 0, 0, 1, 0, acc);
    rst_n = 1;
    idle_cycle(0);

    // Even and odd parity words.
    send_word(7'h55, 0, 0);
    check_eq("tp_even_55", 32'(bus_a.out_data), 32'h55);
    check_eq("tp_even_55_err", 32'(bus_a.word_err), 32'd0);
    send_word(7'h07, 1, 0);
    check_eq("tp_even_07", 32'(bus_a.out_data), 32'h87);
    send_word(7'h07, 1, 1);
    check_eq("tp_odd_07", 32'(bus_a.out_data), 32'h07);
    check_eq("tp_odd_07_err", 32'(bus_a.word_err), 32'd1);
    check_eq("tp_odd_07_cnt", 32'(err_cnt_a), 32'd1);

    // Backpressure: out_ready low for 5 cycles with in_valid high.
    for (int i = 0; i < 5; i++) step(1, 7'h2a, 1, 0, 0, 0, acc);
    for (int i = 0; i < 3; i++) step(1, 7'h2b, 0, 0, 1, 0, acc);
    idle_cycle(0);

    // Clean frame of 1..8, then the same frame with word 3 corrupted.
    idle_cycle(1);
    for (int r = 0; r < 2; r++) begin
      for (int w = 1; w <= FRAME_LEN; w++) begin
        d = 7'(w);
        send_word(d, bit'($countones(d) % 2) ^ ((r == 1) && (w == 3)), 0);
      end
      idle_cycle(0);
      check_eq("tp_frame_err", 32'(frame_err_a), 32'(r));
      idle_cycle(0);
    end

    // Saturation of the 2-bit counter, then clr together with a bad accept.
    idle_cycle(1);
    for (int i = 0; i < 5; i++) begin
      send_word(7'h01, 0, 0);
      check_eq("tp_sat_b", 32'(err_cnt_b), 32'(exp_sat[i]));
    end
    step(1, 7'h01, 0, 0, 1, 1, acc);
    check_eq("tp_clr_a", 32'(err_cnt_a), 32'd0);
    check_eq("tp_clr_b", 32'(err_cnt_b), 32'd0);
    idle_cycle(0);

    // Reset after 4 accepts of a frame: outputs clear immediately.
    for (int i = 0; i < 4; i++) send_word(7'(i + 3), 1, 0);
    rst_n = 0;
    #1;
    check_eq("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check_eq("rst_out_data",  32'(bus_a.out_data),  32'd0);
    check_eq("rst_err_cnt",   32'(err_cnt_a),       32'd0);
    check_eq("rst_in_ready",  32'(bus_a.in_ready),  32'd0);
    model_reset();
    step(0, 7'h00, 0, 0, 1, 0, acc);
    rst_n = 1;
    for (int i = 0; i < FRAME_LEN; i++) send_word(7'(i * 9), 0, 0);
    idle_cycle(0);

    // Exhaustive data values in both parity modes.
    for (int m = 0; m < 2; m++)
      for (int v = 0; v < 128; v++)
        send_word(7'(v), 1'($urandom_range(0, 1)), 1'(m));
    idle_cycle(0);

    // Randomized traffic with occasional clr.
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 3) != 0), 7'($urandom_range(0, 127)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0), acc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
